flapjack_sd_sequencer: RTL and testbench
========================================

FLAPJACK_SD_SEQUENCER -- requirements
Module: flapjack_sd_sequencer

Interface
REQ-001 SHALL have parameter ACMD41_RETRIES, default 255, the maximum number of CMD55/ACMD41 pairs before failing.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4_000_000, the maximum number of clk_sys cycles a single command may take.
REQ-003 SHALL have one clock, clk_sys; reset is asynchronous and active-high.
REQ-004 Port clk_sys  in  1  125 MHz system clock.
REQ-005 Port reset  in  1  asynchronous reset, active-high.
REQ-006 Port sd_cd  in  1  card detect; 0 = card present.
REQ-007 Port req_read  in  1  single-cycle request to read one block.
REQ-008 Port req_lba  in  32  block address, sampled when req_read is accepted.
REQ-009 Port ready  out  1  card initialised and idle.
REQ-010 Port busy  out  1  init or read in progress.
REQ-011 Port done  out  1  one-cycle pulse when a read completes successfully.
REQ-012 Port error  out  1  sticky fault flag.
REQ-013 Port err_code  out  3  fault cause: 0 none, 1 CMD0, 2 CMD8, 3 ACMD41 exhausted, 4 CMD58, 5 CMD17, 6 timeout, 7 card removed.
REQ-014 Port sd_cmd  out  8  command code to the SD shifter block.
REQ-015 Port sd_cmddata  out  16  command argument to the SD shifter block.
REQ-016 Port sd_status  in  9  bit 8 = complete, bit 0 = response matched.

Function
REQ-017 Issue handshake SHALL use the following sequence of states:
- ISS_CLR: drive sd_cmd=0 with sd_cmddata valid, then go to ISS_WCLR.
- ISS_WCLR: wait for sd_status[8]=0; wait a minimum of 2 cycles.
- ISS_SET: drive the command code while holding sd_cmddata, then go to ISS_WAIT.
- ISS_WAIT: wait for sd_status[8]=1, then report ok = sd_status[0].
REQ-018 sd_cmddata SHALL be stable from ISS_CLR until ISS_WAIT exits.
REQ-019 A timeout counter (23 bits) SHALL clear on entry to ISS_CLR; reaching TIMEOUT_CYCLES SHALL force FAULT with err_code=6.
REQ-020 Main FSM states SHALL be NOCARD, I_CMD0, I_CMD8, I_CMD55, I_ACMD41, I_CMD58, IDLE, R_ALO, R_AHI, R_CMD17, FAULT.
REQ-021 Command codes SHALL be: CMD0=1, CMD8=2, CMD55=4, ACMD41=5, CMD58=6, CMD17=7, ADDR_LO=32, ADDR_HI=33.
REQ-022 NOCARD -> I_CMD0 when sd_cd=0 has been stable for 1024 cycles.
REQ-023 Initialisation SHALL proceed I_CMD0 -> I_CMD8 -> I_CMD55 -> I_ACMD41, each step only on ok=1.
REQ-024 A failure of CMD0 or CMD8 SHALL give FAULT with err_code 1 or 2 respectively.
REQ-025 CMD55 status SHALL be ignored; the FSM always proceeds to I_ACMD41.
REQ-026 I_ACMD41 with ok=0 SHALL increment the retry count and return to I_CMD55.
REQ-027 A retry count reaching ACMD41_RETRIES SHALL give FAULT with err_code=3.
REQ-028 I_ACMD41 with ok=1 SHALL go to I_CMD58 (or IDLE, see Configuration).
REQ-029 I_CMD58 SHALL go to IDLE on ok=1 and to FAULT with err_code=4 on ok=0.
REQ-030 IDLE SHALL hold ready=1 and sd_cmd=0.
REQ-031 req_read in IDLE SHALL latch req_lba and enter R_ALO.
REQ-032 req_read outside IDLE SHALL be ignored.
REQ-033 Read sequence SHALL be R_ALO (sd_cmddata=lba[15:0]) -> R_AHI (lba[31:16]) -> R_CMD17.
REQ-034 R_CMD17 with ok=1 SHALL pulse done and return to IDLE; ok=0 SHALL give FAULT with err_code=5.
REQ-035 busy SHALL be 1 in every state except NOCARD, IDLE and FAULT.
REQ-036 ready SHALL be 1 only in IDLE.
REQ-037 sd_cd=1 in any state SHALL enter NOCARD next cycle with sd_cmd=0.
REQ-038 Card removal SHALL set error=1 and err_code=7 unless the FSM is already in NOCARD.
REQ-039 FAULT SHALL hold until card removal; reinsertion restarts init and clears error.
REQ-040 req_read coincident with card removal: removal SHALL win and the request is dropped.

Reset
REQ-041 On reset the FSM SHALL be in NOCARD.
REQ-042 On reset ready, busy, done and error SHALL be 0, err_code SHALL be 0, sd_cmd SHALL be 0 and sd_cmddata SHALL be 0.
REQ-043 On reset the retry count, timeout counter and debounce counter SHALL be 0.
REQ-044 Reset mid-command SHALL abandon the command; sd_cmd=0 is the only guaranteed output.

Configuration
REQ-045 With FLAPJACK_SD_CMD58_CHECK_EN defined, I_CMD58 SHALL be included in the initialisation sequence.
REQ-046 Without FLAPJACK_SD_CMD58_CHECK_EN, ACMD41 ok=1 SHALL go directly to IDLE and err_code 4 SHALL never occur.

Structure
REQ-047 Package flapjack_sd_pkg SHALL hold the command-code constants, the err_code localparams and the main-FSM state enum.
REQ-048 Sub-module flapjack_sd_cmd_issuer SHALL implement REQ-017 to REQ-019 with ports start, code, arg, ok, timeout and fin.

Verification
REQ-049 Card model returns ok=1 for every command -> ready=1 after a sequence of codes 1, 2, 4, 5, 6; err_code=0.
REQ-050 ACMD41 returns ok=0 three times, then ok=1 -> exactly 4 CMD55/ACMD41 pairs are observed, then ready=1.
REQ-051 req_read with req_lba=0x12345678 -> sd_cmddata=0x5678 with code 32, then 0x1234 with code 33, then code 7; done pulses once.
REQ-052 Model never sets sd_status[8] on CMD8 -> FAULT with err_code=6 at TIMEOUT_CYCLES, within ±2 cycles.
REQ-053 sd_cd rises during R_CMD17 -> NOCARD next cycle with err_code=7; sd_cd falls -> init restarts and error clears.
REQ-054 Without the macro defined -> no code 6 is issued and ready=1 follows ACMD41 directly.

Source files
------------

// File: rtl/flapjack_sd_pkg.sv
// Shared constants and state encodings for the flapjack SD init/read sequencer.
package flapjack_sd_pkg;

  localparam logic [7:0] CMD_NONE = 8'd0;
  localparam logic [7:0] CMD0     = 8'd1;
  localparam logic [7:0] CMD8     = 8'd2;
  localparam logic [7:0] CMD55    = 8'd4;
  localparam logic [7:0] ACMD41   = 8'd5;
  localparam logic [7:0] CMD58    = 8'd6;
  localparam logic [7:0] CMD17    = 8'd7;
  localparam logic [7:0] ADDR_LO  = 8'd32;
  localparam logic [7:0] ADDR_HI  = 8'd33;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_CMD0    = 3'd1;
  localparam logic [2:0] ERR_CMD8    = 3'd2;
  localparam logic [2:0] ERR_ACMD41  = 3'd3;
  localparam logic [2:0] ERR_CMD58   = 3'd4;
  localparam logic [2:0] ERR_CMD17   = 3'd5;
  localparam logic [2:0] ERR_TIMEOUT = 3'd6;
  localparam logic [2:0] ERR_REMOVED = 3'd7;

  localparam int DEBOUNCE_CYCLES = 1024;

  typedef enum logic [3:0] {
    NOCARD, I_CMD0, I_CMD8, I_CMD55, I_ACMD41, I_CMD58,
    IDLE, R_ALO, R_AHI, R_CMD17, FAULT
  } main_state_e;

  typedef enum logic [2:0] {
    ISS_IDLE, ISS_CLR, ISS_WCLR, ISS_SET, ISS_WAIT
  } iss_state_e;

endpackage

// File: rtl/flapjack_sd_cmd_issuer.sv
// Clear/set handshake to the SD shifter for one command, with per-command timeout.
module flapjack_sd_cmd_issuer
  import flapjack_sd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4_000_000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  code,
  input  logic [15:0] arg,
  input  logic [8:0]  sd_status,
  output logic [7:0]  sd_cmd,
  output logic [15:0] sd_cmddata,
  output logic        ok,
  output logic        timeout,
  output logic        fin
);

  localparam logic [22:0] TC_LAST = 23'(TIMEOUT_CYCLES - 1);

  iss_state_e  iss_q, iss_d;
  logic [7:0]  code_q;
  logic [15:0] arg_q;
  logic [22:0] tcnt_q;
  logic        wclr_q;
  logic        unused_status;

  assign unused_status = ^sd_status[7:1];

  assign timeout    = (iss_q != ISS_IDLE) && (tcnt_q == TC_LAST);
  assign fin        = (iss_q == ISS_WAIT) && sd_status[8] && !timeout;
  assign ok         = sd_status[0];
  assign sd_cmddata = arg_q;

  always_comb begin
    iss_d  = iss_q;
    sd_cmd = CMD_NONE;
    case (iss_q)
      ISS_IDLE: if (start) iss_d = ISS_CLR;
      ISS_CLR:  iss_d = ISS_WCLR;
      // wclr_q guarantees at least two cycles in ISS_WCLR
      ISS_WCLR: if (!sd_status[8] && wclr_q) iss_d = ISS_SET;
      ISS_SET: begin
        sd_cmd = code_q;
        iss_d  = ISS_WAIT;
      end
      ISS_WAIT: begin
        sd_cmd = code_q;
        if (fin) iss_d = ISS_IDLE;
      end
      default: iss_d = ISS_IDLE;
    endcase
    if (abort || timeout) iss_d = ISS_IDLE;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      iss_q  <= ISS_IDLE;
      code_q <= CMD_NONE;
      arg_q  <= '0;
      tcnt_q <= '0;
      wclr_q <= 1'b0;
    end else begin
      iss_q <= iss_d;
      if (iss_q == ISS_IDLE && start && !abort) begin
        code_q <= code;
        arg_q  <= arg;
      end
      tcnt_q <= (iss_q == ISS_IDLE) ? '0 : tcnt_q + 23'd1;
      wclr_q <= (iss_q == ISS_WCLR);
    end
  end

endmodule

// File: rtl/flapjack_sd_sequencer.sv
// SD card init (CMD0/8/55/ACMD41[/58]) and single-block read sequencer.
// Define FLAPJACK_SD_CMD58_CHECK_EN to add the CMD58 step to initialisation.
module flapjack_sd_sequencer
  import flapjack_sd_pkg::*;
#(
  parameter int ACMD41_RETRIES = 255,
  parameter int TIMEOUT_CYCLES = 4_000_000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        sd_cd,
  input  logic        req_read,
  input  logic [31:0] req_lba,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_code,
  output logic [7:0]  sd_cmd,
  output logic [15:0] sd_cmddata,
  input  logic [8:0]  sd_status
);

  localparam int RW = (ACMD41_RETRIES > 1) ? $clog2(ACMD41_RETRIES + 1) : 1;
  localparam logic [RW-1:0] RETRY_LAST = RW'(ACMD41_RETRIES - 1);
  localparam logic [9:0]    DEB_LAST   = 10'(DEBOUNCE_CYCLES - 1);

  main_state_e state_q, state_d;
  logic [2:0]    err_q, err_d;
  logic          error_q, error_d;
  logic          done_q, done_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [31:0]   lba_q, lba_d;
  logic [9:0]    deb_q;
  logic [7:0]    cmd_code;
  logic [15:0]   cmd_arg;
  logic          iss_ok, iss_timeout, iss_fin;

  assign ready    = (state_q == IDLE);
  assign busy     = !(state_q == NOCARD || state_q == IDLE || state_q == FAULT);
  assign done     = done_q;
  assign error    = error_q;
  assign err_code = err_q;

  flapjack_sd_cmd_issuer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_issuer (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .start      (busy),
    .abort      (sd_cd),
    .code       (cmd_code),
    .arg        (cmd_arg),
    .sd_status  (sd_status),
    .sd_cmd     (sd_cmd),
    .sd_cmddata (sd_cmddata),
    .ok         (iss_ok),
    .timeout    (iss_timeout),
    .fin        (iss_fin)
  );

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    error_d  = error_q;
    retry_d  = retry_q;
    lba_d    = lba_q;
    done_d   = 1'b0;
    cmd_code = CMD_NONE;
    cmd_arg  = '0;
    case (state_q)
      I_CMD0:   cmd_code = CMD0;
      I_CMD8:   cmd_code = CMD8;
      I_CMD55:  cmd_code = CMD55;
      I_ACMD41: cmd_code = ACMD41;
      I_CMD58:  cmd_code = CMD58;
      R_ALO: begin
        cmd_code = ADDR_LO;
        cmd_arg  = lba_q[15:0];
      end
      R_AHI: begin
        cmd_code = ADDR_HI;
        cmd_arg  = lba_q[31:16];
      end
      R_CMD17:  cmd_code = CMD17;
      default:  cmd_code = CMD_NONE;
    endcase

    // Removal outranks everything, including a coincident read request.
    if (sd_cd) begin
      state_d = NOCARD;
      if (state_q != NOCARD) begin
        error_d = 1'b1;
        err_d   = ERR_REMOVED;
      end
    end else if (iss_timeout) begin
      state_d = FAULT;
      error_d = 1'b1;
      err_d   = ERR_TIMEOUT;
    end else begin
      case (state_q)
        NOCARD: if (deb_q == DEB_LAST) begin
          state_d = I_CMD0;
          error_d = 1'b0;
          err_d   = ERR_NONE;
          retry_d = '0;
        end
        I_CMD0: if (iss_fin) begin
          if (iss_ok) state_d = I_CMD8;
          else begin state_d = FAULT; error_d = 1'b1; err_d = ERR_CMD0; end
        end
        I_CMD8: if (iss_fin) begin
          if (iss_ok) state_d = I_CMD55;
          else begin state_d = FAULT; error_d = 1'b1; err_d = ERR_CMD8; end
        end
        I_CMD55: if (iss_fin) state_d = I_ACMD41;
        I_ACMD41: if (iss_fin) begin
          if (iss_ok) begin
`ifdef FLAPJACK_SD_CMD58_CHECK_EN
            state_d = I_CMD58;
`else
            state_d = IDLE;
`endif
          end else if (retry_q == RETRY_LAST) begin
            state_d = FAULT;
            error_d = 1'b1;
            err_d   = ERR_ACMD41;
          end else begin
            retry_d = retry_q + RW'(1);
            state_d = I_CMD55;
          end
        end
        I_CMD58: if (iss_fin) begin
          if (iss_ok) state_d = IDLE;
          else begin state_d = FAULT; error_d = 1'b1; err_d = ERR_CMD58; end
        end
        IDLE: if (req_read) begin
          lba_d   = req_lba;
          state_d = R_ALO;
        end
        R_ALO: if (iss_fin) state_d = R_AHI;
        R_AHI: if (iss_fin) state_d = R_CMD17;
        R_CMD17: if (iss_fin) begin
          if (iss_ok) begin state_d = IDLE; done_d = 1'b1; end
          else begin state_d = FAULT; error_d = 1'b1; err_d = ERR_CMD17; end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= NOCARD;
      err_q   <= ERR_NONE;
      error_q <= 1'b0;
      done_q  <= 1'b0;
      retry_q <= '0;
      lba_q   <= '0;
      deb_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      error_q <= error_d;
      done_q  <= done_d;
      retry_q <= retry_d;
      lba_q   <= lba_d;
      if (state_q != NOCARD || sd_cd) deb_q <= '0;
      else if (deb_q != DEB_LAST)     deb_q <= deb_q + 10'd1;
    end
  end

endmodule

// File: tb/tb_flapjack_sd_sequencer.sv
// Directed bench for flapjack_sd_sequencer with a small behavioural SD shifter/card model.
module tb_flapjack_sd_sequencer;

  localparam int RETRIES = 8;
  localparam int TMO     = 300;
`ifdef FLAPJACK_SD_CMD58_CHECK_EN
  localparam int N_INIT = 5;
`else
  localparam int N_INIT = 4;
`endif

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        sd_cd;
  logic        req_read;
  logic [31:0] req_lba;
  logic        ready, busy, done, error;
  logic [2:0]  err_code;
  logic [7:0]  sd_cmd;
  logic [15:0] sd_cmddata;
  logic [8:0]  sd_status;

  int tests = 0;
  int fails = 0;

  always #4 clk_sys = ~clk_sys;

  flapjack_sd_sequencer #(.ACMD41_RETRIES(RETRIES), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .sd_cd      (sd_cd),
    .req_read   (req_read),
    .req_lba    (req_lba),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .sd_cmd     (sd_cmd),
    .sd_cmddata (sd_cmddata),
    .sd_status  (sd_status)
  );

  // Card model: completes each command 3 cycles after the code appears.
  logic [7:0]  hang_code, fail_code;
  int          acmd_fail_cfg;
  logic [7:0]  prev_cmd;
  int          lat, acmd_seen;
  int          log_n = 0;
  logic [7:0]  log_cmd [256];
  logic [15:0] log_arg [256];

  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sd_status <= '0;
      prev_cmd  <= '0;
      lat       <= 0;
      acmd_seen <= 0;
    end else begin
      prev_cmd <= sd_cmd;
      if (sd_cmd == 8'd0) begin
        sd_status <= '0;
        lat       <= 0;
      end else begin
        if (prev_cmd == 8'd0) begin
          if (log_n < 256) begin
            log_cmd[8'(log_n)] <= sd_cmd;
            log_arg[8'(log_n)] <= sd_cmddata;
          end
          log_n <= log_n + 1;
          if (sd_cmd == 8'd1) acmd_seen <= 0;
        end
        if (!sd_status[8] && sd_cmd != hang_code) begin
          if (lat == 2) begin
            sd_status[8] <= 1'b1;
            if (sd_cmd == 8'd5) begin
              sd_status[0] <= (acmd_seen >= acmd_fail_cfg);
              acmd_seen    <= acmd_seen + 1;
            end else begin
              sd_status[0] <= (sd_cmd != fail_code);
            end
          end else begin
            lat <= lat + 1;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    sd_cd    = 1'b0;
    req_read = 1'b0;
    req_lba  = '0;
    cycles(3);
    reset = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n = 0;
    while (!ready && n < budget) begin @(negedge clk_sys); n++; end
    check(tag, 32'(ready), 32'd1);
  endtask

  task automatic wait_error(input string tag, input int budget);
    int n = 0;
    while (!error && n < budget) begin @(negedge clk_sys); n++; end
    check(tag, 32'(error), 32'd1);
  endtask

  function automatic int count_code(input int base, input logic [7:0] code);
    int c = 0;
    for (int i = base; i < log_n && i < 256; i++)
      if (log_cmd[8'(i)] == code) c++;
    return c;
  endfunction

  logic [7:0] exp_init [5];
  int base, n, dcount;

  initial begin
    exp_init = '{8'd1, 8'd2, 8'd4, 8'd5, 8'd6};
    hang_code = 8'd0; fail_code = 8'd0; acmd_fail_cfg = 0;
    reset = 1'b1; sd_cd = 1'b0; req_read = 1'b0; req_lba = '0;
    cycles(2);
    check("rst_ready",      32'(ready),      32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_error",      32'(error),      32'd0);
    check("rst_err_code",   32'(err_code),   32'd0);
    check("rst_sd_cmd",     32'(sd_cmd),     32'd0);
    check("rst_sd_cmddata", 32'(sd_cmddata), 32'd0);
    reset = 1'b0;

    // Plain init: debounce boundary, ignored early read, command order.
    base = log_n;
    cycles(1000);
    check("debounce_hold", 32'(busy), 32'd0);
    cycles(40);
    check("debounce_done", 32'(busy), 32'd1);
    req_lba = 32'hDEADBEEF; req_read = 1'b1;
    cycles(1);
    req_read = 1'b0;
    wait_ready("init_ready", 3000);
    check("init_ncmds", 32'(log_n - base), 32'(N_INIT));
    for (int i = 0; i < N_INIT; i++)
      check("init_code", 32'(log_cmd[8'(base + i)]), 32'(exp_init[i]));
    check("init_err_code", 32'(err_code), 32'd0);
    check("idle_sd_cmd", 32'(sd_cmd), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Block read of LBA 0x12345678.
    base = log_n;
    req_lba = 32'h12345678; req_read = 1'b1;
    cycles(1);
    req_read = 1'b0; req_lba = '0;
    dcount = 0;
    for (int i = 0; i < 200; i++) begin
      if (done) dcount++;
      @(negedge clk_sys);
    end
    check("read_done_pulses", 32'(dcount), 32'd1);
    check("read_ncmds", 32'(log_n - base), 32'd3);
    check("read_code_lo", 32'(log_cmd[8'(base)]),     32'd32);
    check("read_arg_lo",  32'(log_arg[8'(base)]),     32'h5678);
    check("read_code_hi", 32'(log_cmd[8'(base + 1)]), 32'd33);
    check("read_arg_hi",  32'(log_arg[8'(base + 1)]), 32'h1234);
    check("read_code_17", 32'(log_cmd[8'(base + 2)]), 32'd7);
    check("read_ready", 32'(ready), 32'd1);

    // ACMD41 refuses three times.
    do_reset();
    acmd_fail_cfg = 3;
    base = log_n;
    wait_ready("retry_ready", 4000);
    check("retry_cmd55",  32'(count_code(base, 8'd4)), 32'd4);
    check("retry_acmd41", 32'(count_code(base, 8'd5)), 32'd4);
    check("retry_err_code", 32'(err_code), 32'd0);

    // ACMD41 never accepts: retries exhausted.
    do_reset();
    acmd_fail_cfg = 1000;
    base = log_n;
    wait_error("exhaust_error", 4000);
    check("exhaust_err_code", 32'(err_code), 32'd3);
    check("exhaust_acmd41", 32'(count_code(base, 8'd5)), 32'(RETRIES));
    cycles(50);
    check("fault_hold_error", 32'(error), 32'd1);
    check("fault_hold_busy", 32'(busy), 32'd0);
    check("fault_hold_ready", 32'(ready), 32'd0);

    // CMD8 rejected.
    do_reset();
    acmd_fail_cfg = 0; fail_code = 8'd2;
    wait_error("cmd8_error", 3000);
    check("cmd8_err_code", 32'(err_code), 32'd2);
    fail_code = 8'd0;

    // CMD8 never completes: timeout latency.
    do_reset();
    hang_code = 8'd2;
    n = 0;
    while (sd_cmd != 8'd2 && n < 2000) begin @(negedge clk_sys); n++; end
    check("tmo_cmd8_seen", 32'(sd_cmd), 32'd2);
    n = 0;
    while (!error && n < 1000) begin @(negedge clk_sys); n++; end
    check("tmo_err_code", 32'(err_code), 32'd6);
    check("tmo_latency_window", 32'((n + 3 >= TMO - 2) && (n + 3 <= TMO + 2)), 32'd1);
    hang_code = 8'd0;
    sd_cd = 1'b1;
    cycles(1);
    check("fault_remove_code", 32'(err_code), 32'd7);
    sd_cd = 1'b0;
    wait_ready("fault_recover_ready", 3000);
    check("fault_recover_error", 32'(error), 32'd0);

    // Removal during CMD17, then reinsertion.
    req_lba = 32'hA5A50001; req_read = 1'b1;
    cycles(1);
    req_read = 1'b0;
    n = 0;
    while (sd_cmd != 8'd7 && n < 200) begin @(negedge clk_sys); n++; end
    check("rm_cmd17_seen", 32'(sd_cmd), 32'd7);
    sd_cd = 1'b1;
    cycles(1);
    check("rm_error", 32'(error), 32'd1);
    check("rm_err_code", 32'(err_code), 32'd7);
    check("rm_sd_cmd", 32'(sd_cmd), 32'd0);
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_ready", 32'(ready), 32'd0);
    sd_cd = 1'b0;
    cycles(1030);
    check("reinsert_error_clr", 32'(error), 32'd0);
    check("reinsert_busy", 32'(busy), 32'd1);
    wait_ready("reinsert_ready", 3000);

    // Read request coincident with removal is dropped.
    base = log_n;
    req_lba = 32'h00000042; req_read = 1'b1; sd_cd = 1'b1;
    cycles(1);
    req_read = 1'b0;
    check("coinc_err_code", 32'(err_code), 32'd7);
    cycles(20);
    check("coinc_no_cmds", 32'(log_n - base), 32'd0);
    check("coinc_busy", 32'(busy), 32'd0);
    sd_cd = 1'b0;
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
